difftest_axis_mc_packer: RTL and testbench
==========================================

// Module: difftest_axis_mc_packer
// PURPOSE
//  Multi-channel successor to the single-stream Difftest-to-AXIS path. It buffers up to DEPTH
//  difftest batches per channel and arbitrates round-robin between channels. Each batch is
//  serialised LSB-first into AXIS beats carrying tid, tkeep and tlast. It drives
//  core_clock_enable so the core clock stops before any channel buffer can overflow. Sits
//  between the difftest batch outputs and the XDMA C2H stream.
// PARAMETERS
//  NUM_CH      2     number of difftest channels (>=1)
//  DATA_WIDTH  1024  bits per batch per channel; multiple of 8
//  AXIS_WIDTH  512   AXIS data bits; multiple of 8
//  DEPTH       4     batches buffered per channel (>=2, power of 2)
//  derived: BEATS=ceil(DATA_WIDTH/AXIS_WIDTH); CID_W=max(1,clog2(NUM_CH))
// PORTS
//  clock              in   1                   single clock domain
//  reset              in   1                   synchronous, active-high
//  difftest_data      in   NUM_CH*DATA_WIDTH   channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//  difftest_enable    in   NUM_CH              per-channel batch-valid
//  core_clock_enable  out  1                   high = core may advance one step
//  axis_tvalid        out  1                   AXIS valid
//  axis_tdata         out  AXIS_WIDTH          AXIS data
//  axis_tkeep         out  AXIS_WIDTH/8        byte enables
//  axis_tlast         out  1                   final beat of a batch
//  axis_tid           out  CID_W               source channel of the current batch
//  axis_tready        in   1                   AXIS ready
//  pkt_count          out  32                  batches fully sent; wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (sync, any cycle, including mid-packet):
//   - FIFOs flush; FSM goes to IDLE; rr pointer resets to 0.
//   - Next cycle: axis_tvalid=0, tlast=0, tid=0, tdata=0, tkeep=0, pkt_count=0,
//     core_clock_enable=1.
//  Push:
//   - Channel c pushes DATA_WIDTH bits when difftest_enable[c] && core_clock_enable.
//   - Pushes while core_clock_enable=0 are ignored.
//  core_clock_enable:
//   - Combinational from registered counts only (no tready path).
//   - Equals 1 iff every channel count <= DEPTH-1.
//   - Push and pop on the same channel in the same cycle are legal at any count.
//  FSM IDLE:
//   - If any FIFO is non-empty, grant the first non-empty channel searching from rr,
//     rr+1, ... (mod NUM_CH); latch ch; beat=0; go to SEND.
//   - One bubble cycle per batch; tvalid=0 in IDLE.
//  FSM SEND:
//   - Drives tvalid=1, tid=ch and tdata = head(ch)[beat*AXIS_WIDTH +: AXIS_WIDTH].
//   - On tvalid&&tready with beat<BEATS-1: beat++.
//   - On tvalid&&tready with beat==BEATS-1: pop ch; rr=ch+1 mod NUM_CH; pkt_count++;
//     go to IDLE.
//   - While tready=0, every AXIS output holds stable; tvalid never drops without handshake.
//  Final beat:
//   - R = DATA_WIDTH - (BEATS-1)*AXIS_WIDTH.
//   - tkeep = low R/8 bits set; tdata bits >= R are 0; tlast=1.
//   - Every other beat: tkeep all ones, tlast=0.
//  Latency: push at cycle t -> earliest beat 0 tvalid at t+2 (FIFO write, IDLE grant).
// TESTING
//  1 NUM_CH=2,DW=1024,AW=512; push ch0 once, tready=1 -> 2 beats, tid=0, tkeep=all 1,
//    tlast on beat 1, pkt_count=1.
//  2 DW=1000 -> beat1 tkeep=2^61-1 (61 bytes), tdata[511:488]=0, tlast=1.
//  3 Both channels push on 3 consecutive cycles -> tid order 0,1,0,1,0,1; pkt_count=6.
//  4 tready=0, 4 ch0 pushes (DEPTH=4) -> core_clock_enable=0 after 4th push, 5th push
//    ignored, AXIS outputs stable; tready=1 -> enable=1 the cycle after first pop.
//  5 Random 50% tready, 200 random batches on 2 channels -> scoreboard matches per channel,
//    no loss, no duplication.
//  6 Reset asserted after beat 0 handshake -> next cycle tvalid=0, pkt_count=0; new push
//    restarts at beat 0.

Source files
------------

// File: rtl/difftest_axis_mc_packer.sv
// Purpose: buffers difftest batches per channel, round-robins channels, serialises batches LSB-first into AXIS beats.
// Latency: a push is presented as beat 0 two cycles later (FIFO write, then IDLE grant); one idle bubble between batches.
// Backpressure: tready=0 freezes all AXIS outputs; core_clock_enable drops while any channel FIFO is full.

module difftest_axis_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module difftest_axis_mc_packer #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 1024,
    parameter int AXIS_WIDTH = 512,
    parameter int DEPTH      = 4,
    parameter int CID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] difftest_data,
    input  logic [NUM_CH-1:0]            difftest_enable,
    output logic                         core_clock_enable,
    output logic                         axis_tvalid,
    output logic [AXIS_WIDTH-1:0]        axis_tdata,
    output logic [AXIS_WIDTH/8-1:0]      axis_tkeep,
    output logic                         axis_tlast,
    output logic [CID_W-1:0]             axis_tid,
    input  logic                         axis_tready,
    output logic [31:0]                  pkt_count
);
    localparam int BEATS     = (DATA_WIDTH + AXIS_WIDTH - 1) / AXIS_WIDTH;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int KEEP_W    = AXIS_WIDTH / 8;
    localparam int LAST_BITS = DATA_WIDTH - (BEATS - 1) * AXIS_WIDTH;
    localparam int PAD_W     = BEATS * AXIS_WIDTH;
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [KEEP_W-1:0] LAST_KEEP = {KEEP_W{1'b1}} >> (KEEP_W - LAST_BITS / 8);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]            state;
    logic [CID_W-1:0]      ch;
    logic [CID_W-1:0]      rr;
    logic [BEAT_W-1:0]     beat;
    logic [CNT_W-1:0]      cnt  [NUM_CH];
    logic [DATA_WIDTH-1:0] head [NUM_CH];
    logic [NUM_CH-1:0]     nonempty;
    logic [NUM_CH-1:0]     push_en;
    logic [NUM_CH-1:0]     pop_en;
    logic                  last_beat;
    logic                  send_hs;
    logic                  grant_vld;
    logic [CID_W-1:0]      grant_ch;
    logic [CID_W-1:0]      rr_next;
    logic [PAD_W-1:0]      padded;

    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign send_hs   = (state == ST_SEND) && axis_tready;

    // Only registered counts feed the enable, so tready never reaches the core clock gate.
    always_comb begin
        core_clock_enable = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cnt[c] > CNT_W'(DEPTH - 1)) begin
                core_clock_enable = 1'b0;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push_en[c]  = difftest_enable[c] && core_clock_enable;
        assign pop_en[c]   = send_hs && last_beat && (ch == CID_W'(c));
        assign nonempty[c] = (cnt[c] != '0);

        difftest_axis_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .push     (push_en[c]),
            .push_dat (difftest_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .pop      (pop_en[c]),
            .head_dat (head[c]),
            .count    (cnt[c])
        );
    end

    // Walk downward so the last hit is the nearest non-empty channel at or after rr.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (int'(rr) + i) % NUM_CH;
            if (nonempty[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = CID_W'(idx);
            end
        end
    end

    assign rr_next = (int'(ch) == NUM_CH - 1) ? '0 : ch + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            ch        <= '0;
            rr        <= '0;
            beat      <= '0;
            pkt_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        ch    <= grant_ch;
                        beat  <= '0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (axis_tready) begin
                        if (last_beat) begin
                            rr        <= rr_next;
                            pkt_count <= pkt_count + 32'd1;
                            state     <= ST_IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Zero padding above DATA_WIDTH clears the unused bits of a short final beat.
    always_comb begin
        padded                   = '0;
        padded[DATA_WIDTH-1:0]   = head[ch];
        axis_tvalid              = 1'b0;
        axis_tdata               = '0;
        axis_tkeep               = '0;
        axis_tlast               = 1'b0;
        axis_tid                 = '0;
        if (state == ST_SEND) begin
            axis_tvalid = 1'b1;
            axis_tid    = ch;
            axis_tdata  = padded[beat*AXIS_WIDTH +: AXIS_WIDTH];
            axis_tkeep  = last_beat ? LAST_KEEP : {KEEP_W{1'b1}};
            axis_tlast  = last_beat;
        end
    end
endmodule

// File: tb/tb_difftest_axis_mc_packer.sv
module tb_difftest_axis_mc_packer;
    typedef struct packed {
        logic [511:0] dat;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [2047:0] dd    = '0;
    logic [1:0]    de    = '0;
    logic          cce;
    logic          tvalid;
    logic [511:0]  tdata;
    logic [63:0]   tkeep;
    logic          tlast;
    logic [0:0]    tid;
    logic          tready = 1'b0;
    logic [31:0]   pkt;

    logic [1999:0] dd2 = '0;
    logic [1:0]    de2 = '0;
    logic          cce2;
    logic          tvalid2;
    logic [511:0]  tdata2;
    logic [63:0]   tkeep2;
    logic          tlast2;
    logic [0:0]    tid2;
    logic [31:0]   pkt2;

    int    total  = 0;
    int    passed = 0;
    int    pkt_model = 0;
    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];
    int    tid_log[$];
    beat_t mon_e;
    beat_t held;
    logic  held_tid;
    logic  stall = 1'b0;

    always #5 clock = ~clock;

    difftest_axis_mc_packer u_dut (
        .clock(clock), .reset(reset), .difftest_data(dd), .difftest_enable(de),
        .core_clock_enable(cce), .axis_tvalid(tvalid), .axis_tdata(tdata),
        .axis_tkeep(tkeep), .axis_tlast(tlast), .axis_tid(tid),
        .axis_tready(tready), .pkt_count(pkt)
    );

    difftest_axis_mc_packer #(.DATA_WIDTH(1000)) u_dut2 (
        .clock(clock), .reset(reset), .difftest_data(dd2), .difftest_enable(de2),
        .core_clock_enable(cce2), .axis_tvalid(tvalid2), .axis_tdata(tdata2),
        .axis_tkeep(tkeep2), .axis_tlast(tlast2), .axis_tid(tid2),
        .axis_tready(tready), .pkt_count(pkt2)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [1023:0] mk_data(input int s);
        logic [1023:0] r;
        for (int w = 0; w < 32; w++) r[w*32 +: 32] = {s[15:0], 16'(w)};
        return r;
    endfunction

    function automatic logic [1023:0] rnd_data();
        logic [1023:0] r;
        for (int w = 0; w < 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic sb_push(input int c, input logic [1023:0] d);
        beat_t e;
        for (int b = 0; b < 2; b++) begin
            e.dat  = d[b*512 +: 512];
            e.keep = '1;
            e.last = (b == 1);
            if (c == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [1023:0] d0, input logic [1023:0] d1);
        dd = {d1, d0};
        de = en;
        if (en[0]) sb_push(0, d0);
        if (en[1]) sb_push(1, d1);
        @(posedge clock); #1;
        de = '0;
    endtask

    task automatic wait_drain(input bit rnd, input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0 || tvalid || tvalid2) && n < budget) begin
            if (rnd) tready = 1'($urandom % 2);
            @(posedge clock); #1;
            n++;
        end
        if (n >= budget) begin
            total++;
            $display("FAIL drain_timeout: %0d beats still queued after %0d cycles", q0.size() + q1.size() + q2.size(), n);
        end
        tready = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1; de = '0; de2 = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_tvalid", tvalid, 0);  check("rst_tlast", tlast, 0);
        check("rst_tid", tid, 0);        check("rst_tdata", tdata, 0);
        check("rst_tkeep", tkeep, 0);    check("rst_pkt", pkt, 0);
        check("rst_cce", cce, 1);        check("rst2_tvalid", tvalid2, 0);
        check("rst2_pkt", pkt2, 0);      check("rst2_cce", cce2, 1);
    endtask

    // Scoreboard monitor for the 1024-bit instance, plus output-hold checking under stall.
    always @(negedge clock) begin
        if (reset) begin
            q0.delete(); q1.delete(); q2.delete();
            pkt_model = 0;
            stall = 1'b0;
        end else begin
            check("pkt_count", pkt, 32'(pkt_model));
            if (stall) begin
                check("hold_tvalid", tvalid, 1);
                check("hold_beat", {tdata, tkeep, tlast, tid}, {held.dat, held.keep, held.last, held_tid});
            end
            if (tvalid && tready) begin
                if ((tid == 1'b0 && q0.size() == 0) || (tid == 1'b1 && q1.size() == 0)) begin
                    total++;
                    $display("FAIL sb_extra: beat on tid %0d with no expected beat", tid);
                end else begin
                    mon_e = (tid == 1'b0) ? q0.pop_front() : q1.pop_front();
                    check("beat_tdata", tdata, mon_e.dat);
                    check("beat_tkeep", tkeep, mon_e.keep);
                    check("beat_tlast", tlast, mon_e.last);
                end
                if (tlast) begin
                    pkt_model++;
                    tid_log.push_back(int'(tid));
                end
            end
            stall    = tvalid && !tready;
            held     = '{dat: tdata, keep: tkeep, last: tlast};
            held_tid = tid;
        end
    end

    always @(negedge clock) begin
        if (!reset && tvalid2 && tready) begin
            if (q2.size() == 0) begin
                total++;
                $display("FAIL sb2_extra: unexpected beat from 1000-bit instance");
            end else begin
                mon_e = q2.pop_front();
                check("dw1000_tdata", tdata2, mon_e.dat);
                check("dw1000_tkeep", tkeep2, mon_e.keep);
                check("dw1000_tlast", tlast2, mon_e.last);
                check("dw1000_tid", tid2, 0);
            end
        end
    end

    initial begin
        int exp_tid[6] = '{0, 1, 0, 1, 0, 1};
        int n;
        int sent;
        bit hs;
        logic [1:0] en;
        logic [511:0] b1;

        do_reset();
        check_reset_outputs();

        // Single ch0 batch, first-beat latency of two cycles.
        tready = 1'b1;
        drive(2'b01, mk_data(1), '0);
        check("lat_t1_tvalid", tvalid, 0);
        @(posedge clock); #1;
        check("lat_t2_tvalid", tvalid, 1);
        check("lat_t2_tid", tid, 0);
        wait_drain(0, 50);
        check("t1_pkt", pkt, 1);

        // 1000-bit batch: 61-byte final beat with zeroed top bits.
        b1 = '0;
        b1[487:0] = '1;
        q2.push_back('{dat: {512{1'b1}}, keep: {64{1'b1}}, last: 1'b0});
        q2.push_back('{dat: b1, keep: 64'h1FFF_FFFF_FFFF_FFFF, last: 1'b1});
        dd2 = {1000'b0, {1000{1'b1}}};
        de2 = 2'b01;
        @(posedge clock); #1;
        de2 = '0;
        wait_drain(0, 50);
        check("t2_pkt2", pkt2, 1);

        // Both channels, three cycles: strict alternation.
        do_reset();
        tid_log.delete();
        for (int i = 0; i < 3; i++) drive(2'b11, mk_data(10 + i), mk_data(20 + i));
        wait_drain(0, 100);
        check("t3_tid_count", tid_log.size(), 6);
        for (int i = 0; i < 6 && i < tid_log.size(); i++) check("t3_tid_order", tid_log[i], exp_tid[i]);
        check("t3_pkt", pkt, 6);

        // Fill ch0 under backpressure; enable drops at full and returns after the first pop.
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t4_cce_not_full", cce, 1);
            drive(2'b01, mk_data(40 + i), '0);
        end
        check("t4_cce_full", cce, 0);
        dd[1023:0] = mk_data(99);
        de = 2'b01;
        @(posedge clock); #1;
        de = '0;
        check("t4_cce_hold", cce, 0);
        repeat (3) begin @(posedge clock); #1; end
        tready = 1'b1;
        n = 0; hs = 0;
        while (!hs && n < 20) begin
            @(negedge clock);
            if (tvalid && tlast) hs = 1;
            n++;
        end
        check("t4_first_pop_seen", hs, 1);
        check("t4_cce_before_pop", cce, 0);
        @(posedge clock); #1;
        check("t4_cce_after_pop", cce, 1);
        wait_drain(0, 100);
        check("t4_pkt", pkt, 4);

        // 200 random batches with random tready; the driver behaves like a gated core.
        do_reset();
        sent = 0; n = 0;
        while (sent < 200 && n < 4000) begin
            tready = 1'($urandom % 2);
            if (cce) begin
                en = 2'($urandom % 4);
                if (sent == 199 && en == 2'b11) en = 2'b01;
                drive(en, rnd_data(), rnd_data());
                sent += int'(en[0]) + int'(en[1]);
            end else begin
                @(posedge clock); #1;
            end
            n++;
        end
        if (n >= 4000) begin
            total++;
            $display("FAIL t5_push_timeout: only %0d of 200 batches pushed", sent);
        end
        wait_drain(1, 5000);
        check("t5_pkt", pkt, 200);

        // Reset in the middle of a batch, then a fresh batch starts at beat 0.
        tready = 1'b1;
        drive(2'b01, mk_data(7), '0);
        n = 0; hs = 0;
        while (!hs && n < 20) begin
            @(negedge clock);
            if (tvalid && !tlast) hs = 1;
            n++;
        end
        check("t6_beat0_seen", hs, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        tready = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        check("t6_tvalid", tvalid, 0);
        check("t6_pkt", pkt, 0);
        check("t6_tdata", tdata, 0);
        check("t6_cce", cce, 1);
        tready = 1'b1;
        drive(2'b01, mk_data(8), '0);
        wait_drain(0, 50);
        check("t6_pkt_after", pkt, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
